// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module  : timer_dev
// Brief   : Memory-mapped 32-bit countdown timer (CTRL/PRESET/COUNT) with IRQ
// Revision: 1.0
// ============================================================================
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic w_en;
  logic w_auto;
  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_load;
  logic w_dec;
  logic w_set;
  logic w_int_clr;
  logic w_en_clr;

  assign w_en        = r_ctrl[0];
  assign w_auto      = (r_ctrl[2:1] == 2'b01);
  assign w_wr_ctrl   = WE && (Addr == 2'b00);
  assign w_wr_preset = WE && (Addr == 2'b01);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_set       = 1'b0;
    w_int_clr   = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_en) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count == 32'd0) begin
          w_set       = 1'b1;
          w_state_nxt = ST_INT;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_INT: begin
        if (w_auto) begin
          w_int_clr   = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // A CPU write to CTRL overrides the one-shot En clear on the same edge.
      if (w_wr_ctrl)     r_ctrl    <= Din[3:0];
      else if (w_en_clr) r_ctrl[0] <= 1'b0;
      if (w_wr_preset) r_preset <= Din;
      if (w_load)      r_count  <= r_preset;
      else if (w_dec)  r_count  <= r_count - 32'd1;
      if (w_set)                                     r_irq_flag <= 1'b1;
      else if (w_wr_ctrl || w_wr_preset || w_int_clr) r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      2'b00:   Dout = {28'd0, r_ctrl};
      2'b01:   Dout = r_preset;
      2'b10:   Dout = r_count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = r_ctrl[3] & r_irq_flag;

endmodule
`default_nettype wire

// File: doc/timer_dev.md
# timer_dev

Memory-mapped 32-bit countdown timer on the system bridge, answering CPU word loads and stores at device offsets 0x0/0x4/0x8. The CPU writes it through the bridge store path and reads it back on `Dout`, which the W-stage load-data select forwards to the register file. It drives an interrupt request line toward the CP0 pending bits. It has a one-shot mode and an auto-reload mode.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock; all state cleared on the rising edge with `reset`=1.
- `Addr`  in  2  word offset `Addr[3:2]`: 00 CTRL, 01 PRESET, 10 COUNT, 11 unmapped.
- `WE`  in  1  write strobe, already qualified by the bridge for this device's address range.
- `Din`  in  32  store data.
- `Dout`  out  32  combinational read of the register selected by `Addr`.
- `IRQ`  out  1  interrupt request, equal to `CTRL.IM & irq_flag`.

## Operation
Register map:
- CTRL
  - bit [0] is En, bits [2:1] are Mode, bit [3] is IM, bits [31:4] read 0.
  - Writes update only bits [3:0].
  - Mode 00 is one-shot. Mode 01 is auto-reload. Modes 10/11 behave as 00.
- PRESET: 32-bit read/write.
- COUNT
  - Read-only; writes are ignored.
- Offset 11: reads return 0; writes are ignored.

Write side effects:
- A write to CTRL or PRESET clears `irq_flag`.
- If a clear and a set of `irq_flag` occur on the same edge, the set wins.

FSM (2-bit state, reset → IDLE), evaluated each edge on the current register values:
- IDLE: if En=1, go to LOAD.
- LOAD
  - If En=0, go to IDLE.
  - Otherwise COUNT ← PRESET and go to CNT.
- CNT
  - If En=0, go to IDLE with COUNT held.
  - Else if COUNT=0, go to INT and set `irq_flag` ← 1.
  - Else COUNT ← COUNT−1.
- INT
  - Mode one-shot: CTRL.En ← 0, go to IDLE; `irq_flag` stays 1 until a CTRL or PRESET write.
  - Mode auto-reload: `irq_flag` ← 0 and go to LOAD, so `irq_flag` is a one-cycle pulse.

Boundary cases:
- A CPU CTRL write on the same edge as INT's En clear: the CPU write wins, with En taken from `Din[0]`.
- A PRESET write during CNT does not change COUNT. The new value takes effect at the next LOAD.
- PRESET=0 gives CNT with COUNT=0, then INT on the next edge.
- COUNT never wraps below 0.
- Reset mid-operation returns everything to reset values on that edge regardless of state or `WE`.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, `irq_flag`=0, state IDLE, `IRQ`=0. `Dout` reflects these.
- A write at edge t is visible on `Dout` after t, with zero-cycle read latency.
- One-shot run with PRESET=P, where CTRL is written with En=1 at edge t:
  - LOAD after t+1.
  - COUNT=P after t+2.
  - COUNT=0 after t+2+P.
  - INT and `IRQ`=1 (if IM=1) after t+3+P.
  - En=0 and IDLE after t+4+P.
- Auto-reload: INT recurs every P+3 cycles, and `IRQ` is high for exactly one cycle per period.
- `IRQ` is a registered flag ANDed with the CTRL.IM bit; it has no combinational path from `WE` or `Din`.

## Test plan
- **Reset and reads.** Assert `reset`, then read all four offsets → all 0, `IRQ`=0. Write COUNT=0x55 → COUNT reads 0.
- **One-shot with IM=1.** PRESET=3, then CTRL=0x9 at edge t.
  - → COUNT reads 3, 2, 1, 0 after t+2..t+5.
  - → `IRQ`=1 after t+6.
  - → CTRL reads 0x8 after t+7.
  - → `IRQ` stays 1 until CTRL is written with 0x8, then goes to 0.
- **Auto-reload.** PRESET=2, CTRL=0xB → `IRQ` pulses one cycle wide, 5 cycles apart, for at least 4 periods.
- **Masking and stop.** PRESET=5, CTRL=0x1 → the flag sets but `IRQ` stays 0. Then write CTRL=0x0 mid-count → COUNT freezes at its current value and the state returns to IDLE.
- **PRESET=0 and conflicts.**
  - PRESET=0 → INT one edge after LOAD.
  - A PRESET write during CNT → COUNT is unaffected until the next reload.
  - A CTRL write of 0x9 on the INT edge in one-shot → En stays 1 and the timer reloads.
- **Reset mid-count.** Pulse `reset` while COUNT=0x10 → all registers 0 and `IRQ`=0 on the next cycle, with no further decrement.
